dec_scan_n: RTL and testbench

//   Parametrised registered N-to-2^N one-hot decoder with enable, plus an auto-scan mode.
//   In scan mode the active output walks through all channels with a programmable dwell time.

---
 rtl/dec_scan_pkg.sv | 30 +++
 rtl/dec_scan_n_onehot.sv | 17 +
 rtl/dec_scan_n.sv | 111 +++++++++++
 tb/tb_dec_scan_n.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dec_scan_pkg.sv
// Shared types and helpers for the dec_scan_n decoder/scanner.
package dec_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIRECT,
        ST_SCAN
    } state_e;

    // Widest channel count the search helper supports (N <= 6).
    localparam int unsigned MAX_CH = 64;

    // Cyclic search from cur+1 for the first channel whose mask bit is clear.
    // Returns the channel index, or -1 when every channel is masked.
    function automatic int next_unmasked(input int unsigned cur,
                                         input logic [MAX_CH-1:0] mask,
                                         input int unsigned nch);
        int res;
        int unsigned j;
        res = -1;
        for (int unsigned k = 1; k <= MAX_CH; k++) begin
            j = (cur + k) % nch;
            if (res < 0 && k <= nch && !mask[j]) begin
                res = int'(j);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dec_scan_n_onehot.sv
// Combinational N-to-2^N one-hot decoder with enable.
module dec_onehot #(
    parameter int N = 3
) (
    input  logic [N-1:0]      sel_i,
    input  logic              en_i,
    output logic [2**N-1:0]   dec_o
);

    always_comb begin
        dec_o = '0;
        if (en_i) begin
            dec_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/dec_scan_n.sv
// Registered one-hot decoder with DIRECT and auto-SCAN modes.
// Optional skip-mask support is enabled by defining DEC_SCAN_SKIP_MASK_EN.
module dec_scan_n
    import dec_scan_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      in,
    input  logic [DW-1:0]     dwell,
`ifdef DEC_SCAN_SKIP_MASK_EN
    input  logic [2**N-1:0]   skip_mask,
`endif
    output logic [2**N-1:0]   out,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int NCH = 2**N;

    state_e            state_q, state_d;
    logic [N-1:0]      idx_q, idx_d;
    logic [DW-1:0]     cnt_q, cnt_d;
    logic              wrap_q, wrap_d;
    logic              resume_q, resume_d;
    logic [NCH-1:0]    out_q;
    logic [NCH-1:0]    dec_w;
    logic [NCH-1:0]    mask_w;
    logic [MAX_CH-1:0] mask_ext;
    logic              dec_en;
    int                nxt;
    logic [N-1:0]      nxt_idx;

`ifdef DEC_SCAN_SKIP_MASK_EN
    assign mask_w = skip_mask;
`else
    assign mask_w = '0;
`endif

    always_comb begin
        mask_ext = '0;
        mask_ext[NCH-1:0] = mask_w;
        nxt      = next_unmasked(32'(idx_q), mask_ext, NCH);
        nxt_idx  = nxt[N-1:0];

        state_d  = ST_IDLE;
        idx_d    = idx_q;
        cnt_d    = '0;
        wrap_d   = 1'b0;
        resume_d = resume_q;

        if (!en) begin
            state_d = ST_IDLE;
        end else if (!mode) begin
            state_d  = ST_DIRECT;
            idx_d    = in;
            resume_d = 1'b0;
        end else begin
            state_d  = ST_SCAN;
            resume_d = 1'b1;
            if (state_q != ST_SCAN) begin
                // Re-entry after a pause keeps the held index; any other entry loads in.
                if (!(state_q == ST_IDLE && resume_q)) begin
                    idx_d = in;
                end
            end else if (cnt_q >= dwell) begin
                if (nxt >= 0) begin
                    idx_d  = nxt_idx;
                    wrap_d = (nxt_idx <= idx_q);
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign dec_en = (state_d != ST_IDLE) && !mask_w[idx_d];

    dec_onehot #(.N(N)) u_dec (
        .sel_i (idx_d),
        .en_i  (dec_en),
        .dec_o (dec_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
            resume_q <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
            resume_q <= resume_d;
            out_q    <= dec_w;
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan_n.sv
// Randomised self-checking bench for dec_scan_n (N=3, DW=8) with a behavioural model.
module tb_dec_scan_n;

    localparam int N   = 3;
    localparam int DW  = 8;
    localparam int NCH = 8;

    localparam int M_IDLE   = 0;
    localparam int M_DIRECT = 1;
    localparam int M_SCAN   = 2;

    logic           clk = 1'b0;
    logic           rst, en, mode;
    logic [N-1:0]   in_s;
    logic [DW-1:0]  dwell;
    logic [NCH-1:0] mask;
    logic [NCH-1:0] out_s;
    logic [N-1:0]   idx_s;
    logic           wrap_s;

    int n_cmp = 0;
    int n_bad = 0;

    int m_state, m_idx, m_cnt, m_wrap, m_resume, m_out;

    always #5 clk = ~clk;

    dec_scan_n #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .in        (in_s),
        .dwell     (dwell),
`ifdef DEC_SCAN_SKIP_MASK_EN
        .skip_mask (mask),
`endif
        .out       (out_s),
        .idx       (idx_s),
        .wrap      (wrap_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour, using the mask the DUT sees (all-clear when the feature is off).
    task automatic model_step();
        logic [NCH-1:0] mk;
        int cand[$];
        int pick;
`ifdef DEC_SCAN_SKIP_MASK_EN
        mk = mask;
`else
        mk = '0;
`endif
        if (rst) begin
            m_state = M_IDLE; m_idx = 0; m_cnt = 0; m_wrap = 0; m_resume = 0;
        end else if (!en) begin
            m_state = M_IDLE; m_cnt = 0; m_wrap = 0;
        end else if (!mode) begin
            m_state = M_DIRECT; m_idx = int'(in_s); m_cnt = 0; m_wrap = 0; m_resume = 0;
        end else if (m_state != M_SCAN) begin
            if (!(m_state == M_IDLE && m_resume == 1)) m_idx = int'(in_s);
            m_state = M_SCAN; m_cnt = 0; m_wrap = 0; m_resume = 1;
        end else begin
            m_wrap = 0;
            if (m_cnt >= int'(dwell)) begin
                m_cnt = 0;
                for (int c = 0; c < NCH; c++) if (!mk[c]) cand.push_back(c);
                if (cand.size() > 0) begin
                    pick = -1;
                    foreach (cand[i]) if (pick < 0 && cand[i] > m_idx) pick = cand[i];
                    if (pick < 0) begin
                        pick = cand[0];
                        m_wrap = 1;
                    end
                    m_idx = pick;
                end
            end else begin
                m_cnt++;
            end
        end
        m_out = (m_state != M_IDLE && !mk[m_idx]) ? (1 << m_idx) : 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("out", 32'(out_s), 32'(m_out));
        check("idx", 32'(idx_s), 32'(m_idx));
        check("wrap", 32'(wrap_s), 32'(m_wrap));
    endtask

    initial begin
        int exp_idx [10];
        int exp_wrp [10];
        int last_wrap;

        rst = 1'b1; en = 1'b1; mode = 1'b1; in_s = 3'd3; dwell = 8'd1; mask = '0;
        m_state = M_IDLE; m_idx = 0; m_cnt = 0; m_wrap = 0; m_resume = 0; m_out = 0;
        cycle(); cycle();
        check("rst_out", 32'(out_s), 32'h0);
        check("rst_idx", 32'(idx_s), 32'h0);
        check("rst_wrap", 32'(wrap_s), 32'h0);
        rst = 1'b0;
        cycle();
        check("scan_start_idx", 32'(idx_s), 32'd3);
        check("scan_start_out", 32'(out_s), 32'h08);

        mode = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            in_s = 3'(i);
            cycle();
            check("direct_out", 32'(out_s), 32'(1) << i);
            if (i == 5) check("direct_in5", 32'(out_s), 32'h20);
        end
        en = 1'b0;
        cycle();
        check("en_off", 32'(out_s), 32'h0);

        exp_idx = '{6, 6, 6, 7, 7, 7, 0, 0, 0, 1};
        exp_wrp = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        en = 1'b1; mode = 1'b1; in_s = 3'd6; dwell = 8'd2;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("dwell2_idx", 32'(idx_s), 32'(exp_idx[i]));
            check("dwell2_wrap", 32'(wrap_s), 32'(exp_wrp[i]));
        end

        dwell = 8'd0;
        last_wrap = -1;
        for (int i = 0; i < 26; i++) begin
            cycle();
            if (wrap_s) begin
                if (last_wrap >= 0) check("wrap_period", 32'(i - last_wrap), 32'd8);
                last_wrap = i;
            end
        end
        check("wrap_seen", 32'(last_wrap >= 0), 32'd1);

        mode = 1'b0; in_s = 3'd4;
        cycle();
        mode = 1'b1; dwell = 8'd2;
        cycle(); cycle();
        check("pause_pre_idx", 32'(idx_s), 32'd4);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("pause_out", 32'(out_s), 32'h0);
            check("pause_idx", 32'(idx_s), 32'd4);
        end
        en = 1'b1; in_s = 3'd0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("resume_idx", 32'(idx_s), 32'd4);
        end
        cycle();
        check("resume_adv", 32'(idx_s), 32'd5);

`ifdef DEC_SCAN_SKIP_MASK_EN
        mask = 8'b0000_1100; dwell = 8'd0; mode = 1'b0; in_s = 3'd1;
        cycle();
        mode = 1'b1;
        cycle();
        check("mask_entry", 32'(idx_s), 32'd1);
        exp_idx[0:5] = '{4, 5, 6, 7, 0, 1};
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("mask_idx", 32'(idx_s), 32'(exp_idx[i]));
        end
        mask = 8'hFF;
        cycle();
        check("mask_all_out", 32'(out_s), 32'h0);
        check("mask_all_idx", 32'(idx_s), 32'd1);
        mask = '0;
`endif

        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            en    = ($urandom_range(0, 9) != 0);
            mode  = ($urandom_range(0, 3) != 0);
            in_s  = 3'($urandom_range(0, NCH - 1));
            if ($urandom_range(0, 15) == 0) dwell = 8'($urandom_range(0, 4));
`ifdef DEC_SCAN_SKIP_MASK_EN
            if ($urandom_range(0, 31) == 0) mask = 8'($urandom) & 8'($urandom);
`endif
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
